// File: rtl/mips_mc_control.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB per opcode and drives datapath strobes.
// Optional build macro ILLEGAL_TRAP_EN turns illegal opcodes into a halting error instead of a NOP.
module mips_mc_control #(
  parameter int MUL_MAX_CYCLES = 32,
  parameter int CNT_W          = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       instr_op,
  input  logic             alu_zero,
  input  logic             mul_done,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             rf_read_en,
  output logic             alu_src_imm,
  output logic [1:0]       alu_op,
  output logic             mul_start,
  output logic             mem_read,
  output logic             mem_write,
  output logic             rf_write,
  output logic [1:0]       rf_wsel,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  localparam int MCNT_W = $clog2(MUL_MAX_CYCLES + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MULW   = 3'd4;
  localparam logic [2:0] S_MEM    = 3'd5;
  localparam logic [2:0] S_WB     = 3'd6;
  localparam logic [2:0] S_HALT   = 3'd7;

  localparam logic [5:0] OP_HALT  = 6'd0;
  localparam logic [5:0] OP_ADDU  = 6'd1;
  localparam logic [5:0] OP_BEQ   = 6'd2;
  localparam logic [5:0] OP_LW    = 6'd3;
  localparam logic [5:0] OP_MUL   = 6'd4;
  localparam logic [5:0] OP_ADDIU = 6'd5;
  localparam logic [5:0] OP_SW    = 6'd6;
  localparam logic [5:0] OP_J     = 6'd7;
  localparam logic [5:0] OP_JR    = 6'd8;

  localparam logic [1:0] PC_INC = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;
  localparam logic [1:0] PC_REG = 2'd3;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;

  localparam logic [1:0] WSEL_ALU = 2'd0;
  localparam logic [1:0] WSEL_MEM = 2'd1;
  localparam logic [1:0] WSEL_MUL = 2'd2;

  localparam logic [MCNT_W-1:0] MUL_LAST = MCNT_W'(MUL_MAX_CYCLES - 1);

  logic [2:0]        state_q,   state_d;
  logic [5:0]        op_q,      op_d;
  logic [MCNT_W-1:0] mul_cnt_q, mul_cnt_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              err_q,     err_d;
  logic              retire;

  // Next-state, opcode latch, multiplier watchdog and retire bookkeeping.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves a latch.
    state_d   = state_q;
    op_d      = op_q;
    mul_cnt_d = '0;
    err_d     = err_q;
    retire    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        op_d = instr_op;
        if (instr_op == OP_HALT) begin
          state_d = S_HALT;
        end else if (instr_op > OP_JR) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_HALT;
          err_d   = 1'b1;
`else
          state_d = S_FETCH;
          retire  = 1'b1;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_ADDU, OP_ADDIU: state_d = S_WB;
          OP_LW, OP_SW:      state_d = S_MEM;
          OP_MUL:            state_d = S_MULW;
          OP_BEQ, OP_J, OP_JR: begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
          default:           state_d = S_FETCH;
        endcase
      end
      S_MULW: begin
        // Counter holds the number of MULW cycles already spent without a result.
        if (mul_done) begin
          state_d = S_WB;
        end else if (mul_cnt_q == MUL_LAST) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          mul_cnt_d = mul_cnt_q + 1'b1;
        end
      end
      S_MEM: begin
        if (op_q == OP_SW) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    retired_d = retired_q;
    if (retire && (retired_q != {CNT_W{1'b1}})) retired_d = retired_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= OP_HALT;
      mul_cnt_q <= '0;
      retired_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      mul_cnt_q <= mul_cnt_d;
      retired_q <= retired_d;
      err_q     <= err_d;
    end
  end

  // Moore decode of the datapath strobes; alu_zero only gates the beq PC update.
  always_comb begin
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PC_INC;
    rf_read_en  = 1'b0;
    alu_src_imm = 1'b0;
    alu_op      = ALU_ADD;
    mul_start   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    rf_write    = 1'b0;
    rf_wsel     = WSEL_ALU;

    case (state_q)
      S_FETCH: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
      end
      S_DECODE: rf_read_en = 1'b1;
      S_EXEC: begin
        case (op_q)
          OP_ADDIU, OP_LW, OP_SW: alu_src_imm = 1'b1;
          OP_BEQ: begin
            alu_op   = ALU_SUB;
            pc_src   = PC_BR;
            pc_write = alu_zero;
          end
          OP_J: begin
            pc_write = 1'b1;
            pc_src   = PC_JMP;
          end
          OP_JR: begin
            pc_write = 1'b1;
            pc_src   = PC_REG;
          end
          OP_MUL:  mul_start = 1'b1;
          default: alu_op    = ALU_ADD;
        endcase
      end
      S_MEM: begin
        if (op_q == OP_SW) mem_write = 1'b1;
        else               mem_read  = 1'b1;
      end
      S_WB: begin
        rf_write = 1'b1;
        case (op_q)
          OP_LW:   rf_wsel = WSEL_MEM;
          OP_MUL:  rf_wsel = WSEL_MUL;
          default: rf_wsel = WSEL_ALU;
        endcase
      end
      default: ir_write = 1'b0;
    endcase
  end

  assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted  = (state_q == S_HALT);
  assign err     = err_q;
  assign retired = retired_q;

endmodule
